// File: rtl/slow_clock_monitor.sv
// Receive-side checker for a divider-generated slow clock: synchronises clk_in,
// ticks once per rising edge, measures each period and reports lock / range / loss.
module slow_clock_monitor #(
  parameter int EXP_PERIOD = 10_000_000,
  parameter int TOL        = 100_000,
  parameter int TIMEOUT    = 20_000_000,
  parameter int LOCK_CNT   = 3,
  parameter int CNT_W      = 25
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             clk_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_range,
  output logic             lock,
  output logic             clk_lost
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  PERIOD_LO  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  PERIOD_HI  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_CNT_C = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK, LOST} state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;
  logic [1:0]          r_fill;
  logic                r_armed;
  logic [CNT_W-1:0]    r_cnt;
  logic [GOOD_W-1:0]   r_good;

  logic                w_edge;
  logic                w_timeout;
  logic                w_in_range;
  logic [GOOD_W-1:0]   w_good_next;

  // r_fill marks when r_sync2 holds a real sample of clk_in rather than its
  // reset value, so a clk_in already high at reset release never arms us.
  assign w_edge      = r_armed & r_sync2 & ~r_prev;
  assign w_timeout   = (r_cnt == TIMEOUT_C) & ~w_edge;
  assign w_in_range  = (r_cnt >= PERIOD_LO) && (r_cnt <= PERIOD_HI);
  assign w_good_next = (r_good == LOCK_CNT_C) ? r_good : r_good + GOOD_ONE;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_fill       <= 2'b00;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_good       <= '0;
      edge_tick    <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      lock         <= 1'b0;
      clk_lost     <= 1'b0;
    end else begin
      r_sync1      <= clk_in;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_fill       <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) r_armed <= 1'b1;

      edge_tick    <= w_edge;
      period_valid <= 1'b0;

      if (w_edge)                 r_cnt <= CNT_ONE;
      else if (r_cnt != TIMEOUT_C) r_cnt <= r_cnt + CNT_ONE;

      case (r_state)
        IDLE: begin
          if (w_edge) r_state <= FIRST;
        end
        FIRST, TRACK: begin
          if (w_edge) begin
            r_state      <= TRACK;
            period_valid <= 1'b1;
            period_out   <= r_cnt;
            in_range     <= w_in_range;
            if (w_in_range) begin
              r_good <= w_good_next;
              lock   <= (w_good_next == LOCK_CNT_C);
            end else begin
              r_good <= '0;
              lock   <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state  <= LOST;
            clk_lost <= 1'b1;
            lock     <= 1'b0;
            r_good   <= '0;
          end
        end
        LOST: begin
          if (w_edge) begin
            r_state  <= FIRST;
            clk_lost <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Randomised bench for slow_clock_monitor: an event-level model predicts every
// output each cycle from the times at which the bench raises clk_in.
module tb_slow_clock_monitor;

  localparam int EXP_PERIOD = 100;
  localparam int TOL        = 5;
  localparam int TIMEOUT    = 250;
  localparam int LOCK_CNT   = 3;
  localparam int CNT_W      = 9;

  logic             clk_100MHz = 1'b0;
  logic             reset_n    = 1'b0;
  logic             clk_in     = 1'b0;
  logic             edge_tick;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             in_range;
  logic             lock;
  logic             clk_lost;

  slow_clock_monitor #(
    .EXP_PERIOD(EXP_PERIOD),
    .TOL       (TOL),
    .TIMEOUT   (TIMEOUT),
    .LOCK_CNT  (LOCK_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .clk_in      (clk_in),
    .edge_tick   (edge_tick),
    .period_out  (period_out),
    .period_valid(period_valid),
    .in_range    (in_range),
    .lock        (lock),
    .clk_lost    (clk_lost)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: expected tick cycles plus per-period bookkeeping.
  int tick_q[$];
  bit m_armed, m_seen;
  int m_last;
  bit m_tick, m_valid, m_inr, m_lock, m_lost;
  int m_period, m_good;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    tick_q.delete();
    m_seen = 0; m_last = 0; m_tick = 0; m_valid = 0;
    m_inr = 0; m_lock = 0; m_lost = 0; m_period = 0; m_good = 0;
  endtask

  task automatic model_posedge();
    m_tick  = 0;
    m_valid = 0;
    if (tick_q.size() > 0 && tick_q[0] == cyc) begin
      void'(tick_q.pop_front());
      m_tick = 1;
      if (m_seen) begin
        m_period = (cyc - m_last > TIMEOUT) ? TIMEOUT : cyc - m_last;
        m_valid  = 1;
        m_inr    = (m_period >= EXP_PERIOD - TOL) && (m_period <= EXP_PERIOD + TOL);
        if (m_inr) begin
          if (m_good < LOCK_CNT) m_good++;
          m_lock = (m_good == LOCK_CNT);
        end else begin
          m_good = 0;
          m_lock = 0;
        end
      end else begin
        m_seen = 1;
        m_lost = 0;
      end
      m_last = cyc;
    end else if (m_seen && (cyc - m_last == TIMEOUT)) begin
      m_lost = 1;
      m_lock = 0;
      m_good = 0;
      m_seen = 0;
    end
  endtask

  task automatic check_all();
    check("edge_tick",    32'(edge_tick),    32'(m_tick));
    check("period_valid", 32'(period_valid), 32'(m_valid));
    check("period_out",   32'(period_out),   m_period);
    check("in_range",     32'(in_range),     32'(m_inr));
    check("lock",         32'(lock),         32'(m_lock));
    check("clk_lost",     32'(clk_lost),     32'(m_lost));
  endtask

  // NOTE: clk_in changes on the falling edge so it is stable well before the
  // next rising edge; a rise at that point produces a tick three edges later.
  task automatic step(input logic nxt);
    @(posedge clk_100MHz);
    cyc++;
    model_posedge();
    @(negedge clk_100MHz);
    check_all();
    if (!clk_in && nxt && m_armed) tick_q.push_back(cyc + 3);
    if (clk_in && !nxt) m_armed = 1;
    clk_in = nxt;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic periods(input int per);
    hold(1'b1, per / 2);
    hold(1'b0, per - per / 2);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_edge_tick",    32'(edge_tick),    0);
    check("rst_period_valid", 32'(period_valid), 0);
    check("rst_period_out",   32'(period_out),   0);
    check("rst_in_range",     32'(in_range),     0);
    check("rst_lock",         32'(lock),         0);
    check("rst_clk_lost",     32'(clk_lost),     0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_100MHz);
      cyc++;
    end
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    model_reset();
    m_armed = !clk_in;
  endtask

  initial begin
    model_reset();
    m_armed = 0;
    @(negedge clk_100MHz);
    do_reset();
    hold(1'b0, 5);

    // Steady 100-cycle clock: lock on the third valid period.
    for (int i = 0; i < 6; i++) periods(100);
    // One long period drops lock, then it recovers.
    periods(110);
    for (int i = 0; i < 4; i++) periods(100);
    // Clock stops long enough to be declared lost, then restarts.
    hold(1'b0, 300);
    for (int i = 0; i < 4; i++) periods(100);
    // Random jitter around the expected period, straddling the tolerance.
    for (int i = 0; i < 20; i++) periods(int'($urandom_range(90, 112)));
    for (int i = 0; i < 4; i++) periods(100);
    // Timeout boundary: exactly TIMEOUT, one past, one short.
    periods(250);
    periods(251);
    periods(249);
    for (int i = 0; i < 4; i++) periods(100);
    // Reset mid-period while locked with clk_in low.
    hold(1'b1, 50);
    hold(1'b0, 20);
    do_reset();
    hold(1'b0, 5);
    for (int i = 0; i < 4; i++) periods(100);
    // Reset while clk_in is high: no tick until it has been seen low.
    hold(1'b1, 30);
    do_reset();
    hold(1'b1, 10);
    hold(1'b0, 20);
    for (int i = 0; i < 5; i++) periods(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
